// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and helpers for the buffered UART transmit front-end.
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StLaunch   = 2'd1,
        StWaitBusy = 2'd2,
        StWaitDone = 2'd3
    } tx_state_e;

    localparam int unsigned DataW = 8;

    // Occupancy needs one bit more than the pointers so that DEPTH itself fits.
    function automatic int unsigned count_width(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Circular byte FIFO with registered full/empty flags and a sticky overflow flag.
module uart_tx_fifo_sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_wr_en,
    input  logic [DataW-1:0]                 i_wr_data,
    input  logic                             i_pop,
    input  logic                             i_clr_flags,
    output logic [DataW-1:0]                 o_rd_data,
    output logic                             o_full,
    output logic                             o_empty,
    output logic [count_width(ADDR_W)-1:0]   o_count,
    output logic                             o_overflow
);

    localparam int unsigned CntW = count_width(ADDR_W);

    logic [DataW-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;
    logic              wr_accept;

    // Acceptance is judged on the registered full flag, so a same-cycle pop cannot rescue a write.
    assign wr_accept = i_wr_en && !full_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (i_pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        unique case ({wr_accept, i_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        if (i_wr_en && full_q) begin
            overflow_d = 1'b1;
        end else if (i_clr_flags) begin
            overflow_d = 1'b0;
        end

        full_d  = (count_d == CntW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; pointers and count define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    assign o_rd_data  = mem_q[rd_ptr_q];
    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_count    = count_q;
    assign o_overflow = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered transmit front-end: queues host bytes and hands them one at a time to the UART TX.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned BUSY_TIMEOUT = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [DataW-1:0]                 i_wr_data,
    input  logic                             i_wr_en,
    output logic                             o_full,
    output logic                             o_empty,
    output logic [count_width(ADDR_W)-1:0]   o_count,
    output logic                             o_overflow,
    input  logic                             i_clr_flags,
    output logic                             o_tx_err,
    output logic [DataW-1:0]                 o_tx_data,
    output logic                             o_tx_start,
    input  logic                             i_tx_busy
);

    localparam int unsigned TmrW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TmrW-1:0] TmrLast = TmrW'(BUSY_TIMEOUT - 1);

    tx_state_e        state_q, state_d;
    logic [TmrW-1:0]  timer_q, timer_d;
    logic [DataW-1:0] tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;
    logic             tx_err_q, tx_err_d;
    logic             pop;
    logic             err_set;
    logic [DataW-1:0] head_data;
    logic             fifo_empty;

    uart_tx_fifo_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wr_en     (i_wr_en),
        .i_wr_data   (i_wr_data),
        .i_pop       (pop),
        .i_clr_flags (i_clr_flags),
        .o_rd_data   (head_data),
        .o_full      (o_full),
        .o_empty     (fifo_empty),
        .o_count     (o_count),
        .o_overflow  (o_overflow)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        err_set   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && !i_tx_busy) begin
                    pop       = 1'b1;
                    tx_data_d = head_data;
                    state_d   = StLaunch;
                end
            end
            StLaunch: begin
                timer_d = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (i_tx_busy) begin
                    state_d = StWaitDone;
                end else if (timer_q == TmrLast) begin
                    // The transmitter never acknowledged; the byte is abandoned.
                    err_set = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TmrW'(1);
                end
            end
            StWaitDone: begin
                if (!i_tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        tx_start_d = (state_d == StLaunch);

        if (err_set) begin
            tx_err_d = 1'b1;
        end else if (i_clr_flags) begin
            tx_err_d = 1'b0;
        end else begin
            tx_err_d = tx_err_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            tx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            tx_err_q   <= tx_err_d;
        end
    end

    assign o_empty    = fifo_empty;
    assign o_tx_err   = tx_err_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;

endmodule
